alu_share_ctrl: RTL

Sequencer and 2-way round-robin arbiter that shares one combinational 32-bit ALU (6-bit function code) between two requesters, e.g. the main datapath and an address/iteration unit.
Each requester uses a valid/ready request channel and a valid/ready response channel.
The block registers operands into the ALU and waits a function-dependent number of cycles; the multiplier path gets extra settle time.
It captures the result and holds it until the owning requester accepts it.

---
 rtl/alu_ctrl_pkg.sv | 29 ++
 rtl/rr_arbiter_2.sv | 16 +
 rtl/alu_share_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sharing controller.
package alu_ctrl_pkg;

    // Sequencer states; the fourth 2-bit code is unused and recovers to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Base opcodes carried in F[2:0].
    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SLT   = 3'd3;
    localparam logic [2:0] OP_NOTA  = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;
    localparam logic [2:0] OP_SHIFT = 3'd7;

    // F[3] inverts B and supplies carry-in inside the ALU.
    localparam int F_INVB = 3;

    // Multiplies need the longer operand hold time.
    function automatic logic is_mul(input logic [2:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant; the last-grant history lives in the caller.
module rr_arbiter_2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    // Requester 0 wins when alone or when requester 1 was served last.
    always_comb begin
        gnt0 = valid0 & (~valid1 | last_grant);
        gnt1 = valid1 & ~gnt0;
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: arbitrate, hold the
// operands for a function-dependent number of cycles, capture the result and
// hold it until the owning requester takes it.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FW         = 6,
    parameter int MUL_CYCLES = 3,
    parameter int ALU_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FW-1:0]    req0_f,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FW-1:0]    req1_f,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FW-1:0]    alu_f,
    input  logic [WIDTH-1:0] alu_y,
    output logic             busy
);

    localparam int MAX_CYC = (MUL_CYCLES > ALU_CYCLES) ? MUL_CYCLES : ALU_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] ALU_LOAD = CW'(ALU_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [FW-1:0]    alu_f_q, alu_f_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] rsp0_y_q, rsp0_y_d, rsp1_y_q, rsp1_y_d;
    logic             rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic             busy_q, busy_d;
    logic             gnt0, gnt1;
    logic [FW-1:0]    sel_f;

    rr_arbiter_2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    assign req0_ready = (state_q == ST_IDLE) & gnt0;
    assign req1_ready = (state_q == ST_IDLE) & gnt1;
    assign sel_f      = gnt1 ? req1_f : req0_f;

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_f      = alu_f_q;
    assign rsp0_y     = rsp0_y_q;
    assign rsp1_y     = rsp1_y_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign busy       = busy_q;

    // Next-state logic: accept in idle, count down in exec, wait for the taker in resp.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_f_d      = alu_f_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp0_y_d     = rsp0_y_q;
        rsp1_y_d     = rsp1_y_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0 | gnt1) begin
                    alu_a_d      = gnt1 ? req1_a : req0_a;
                    alu_b_d      = gnt1 ? req1_b : req0_b;
                    alu_f_d      = sel_f;
                    owner_d      = gnt1;
                    last_grant_d = gnt1;
                    cnt_d        = is_mul(sel_f[2:0]) ? MUL_LOAD : ALU_LOAD;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        rsp1_y_d     = alu_y;
                        rsp1_valid_d = 1'b1;
                    end else begin
                        rsp0_y_d     = alu_y;
                        rsp0_valid_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, operand and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_f_q      <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp0_y_q     <= '0;
            rsp1_y_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_f_q      <= alu_f_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp0_y_q     <= rsp0_y_d;
            rsp1_y_q     <= rsp1_y_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

endmodule
